// File: rtl/itcm_loader_pkg.sv
// rtl/itcm_loader_pkg.sv - shared state encoding and ITCM geometry helpers for itcm_loader
package itcm_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    // Number of 32-bit words addressable by a byte address of the given width.
    function automatic int word_depth(input int addr_width);
        return 1 << (addr_width - 2);
    endfunction

endpackage

// File: rtl/itcm_loader.sv
// rtl/itcm_loader.sv - streams a byte image into the ITCM as packed words while holding the CPU in reset
// Optional feature: ITCM_LOADER_CHECKSUM_EN adds load_csum_o, a running 32-bit sum of committed words.
`ifndef ITCM_ADDR_WIDTH
`define ITCM_ADDR_WIDTH 12
`endif

module itcm_loader
    import itcm_loader_pkg::*;
#(
    parameter int ITCM_ADDR_WIDTH = `ITCM_ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_start_i,
    input  logic                       byte_valid_i,
    input  logic [7:0]                 byte_data_i,
    input  logic                       byte_last_i,
    output logic                       byte_ready_o,
    output logic                       itcm_we_o,
    output logic [ITCM_ADDR_WIDTH-3:0] itcm_waddr_o,
    output logic [31:0]                itcm_wdata_o,
    input  logic                       itcm_ready_i,
    output logic                       cpu_hold_o,
    output logic                       load_done_o,
    output logic                       load_err_o,
`ifdef ITCM_LOADER_CHECKSUM_EN
    output logic [31:0]                load_csum_o,
`endif
    output logic [ITCM_ADDR_WIDTH-2:0] word_cnt_o
);

    localparam int WAW = ITCM_ADDR_WIDTH - 2;
    localparam int CW  = ITCM_ADDR_WIDTH - 1;
    localparam logic [WAW-1:0] TOP_ADDR = WAW'(word_depth(ITCM_ADDR_WIDTH) - 1);

    state_t         state_q;
    logic [1:0]     byte_idx_q;
    logic [31:0]    wdata_q, wdata_d;
    logic [WAW-1:0] waddr_q;
    logic [CW-1:0]  word_cnt_q;
    logic           last_q;
    logic           ready_q, we_q, hold_q, done_q, err_q;
`ifdef ITCM_LOADER_CHECKSUM_EN
    logic [31:0]    csum_q;
`endif

    logic accept;
    assign accept = byte_valid_i && ready_q;

    // Lane 0 starts a fresh word, so upper lanes of a short final word read as zero.
    always_comb begin
        wdata_d = (byte_idx_q == 2'd0) ? 32'd0 : wdata_q;
        case (byte_idx_q)
            2'd0:    wdata_d[7:0]   = byte_data_i;
            2'd1:    wdata_d[15:8]  = byte_data_i;
            2'd2:    wdata_d[23:16] = byte_data_i;
            default: wdata_d[31:24] = byte_data_i;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            byte_idx_q <= 2'd0;
            wdata_q    <= 32'd0;
            waddr_q    <= '0;
            word_cnt_q <= '0;
            last_q     <= 1'b0;
            ready_q    <= 1'b0;
            we_q       <= 1'b0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef ITCM_LOADER_CHECKSUM_EN
            csum_q     <= 32'd0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load_start_i) begin
                        state_q <= ST_FILL;
                        ready_q <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (accept) begin
                        wdata_q <= wdata_d;
                        if (byte_last_i || byte_idx_q == 2'd3) begin
                            state_q    <= ST_WRITE;
                            ready_q    <= 1'b0;
                            we_q       <= 1'b1;
                            last_q     <= byte_last_i;
                            byte_idx_q <= 2'd0;
                        end else begin
                            byte_idx_q <= byte_idx_q + 2'd1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (itcm_ready_i) begin
                        we_q       <= 1'b0;
                        word_cnt_q <= word_cnt_q + CW'(1);
`ifdef ITCM_LOADER_CHECKSUM_EN
                        csum_q     <= csum_q + wdata_q;
`endif
                        // The address saturates at the top word rather than wrapping onto word 0.
                        if (waddr_q != TOP_ADDR)
                            waddr_q <= waddr_q + WAW'(1);
                        if (last_q) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            hold_q  <= 1'b0;
                        end else if (waddr_q == TOP_ADDR) begin
                            state_q <= ST_ERR;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= ST_FILL;
                            ready_q <= 1'b1;
                        end
                    end
                end
                ST_DONE, ST_ERR: begin
                    if (load_start_i) begin
                        state_q    <= ST_FILL;
                        ready_q    <= 1'b1;
                        hold_q     <= 1'b1;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        waddr_q    <= '0;
                        word_cnt_q <= '0;
                        byte_idx_q <= 2'd0;
                        last_q     <= 1'b0;
`ifdef ITCM_LOADER_CHECKSUM_EN
                        csum_q     <= 32'd0;
`endif
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign byte_ready_o = ready_q;
    assign itcm_we_o    = we_q;
    assign itcm_waddr_o = waddr_q;
    assign itcm_wdata_o = wdata_q;
    assign cpu_hold_o   = hold_q;
    assign load_done_o  = done_q;
    assign load_err_o   = err_q;
    assign word_cnt_o   = word_cnt_q;
`ifdef ITCM_LOADER_CHECKSUM_EN
    assign load_csum_o  = csum_q;
`endif

endmodule
